// File: rtl/keypad_scan_ctrl.sv
// 4x4 keypad column scanner with row synchronizer, scan-level debounce
// and a one-entry ready/valid press/release event buffer.
module keypad_scan_ctrl #(
   parameter int scan_cycles_p    = 50000,
   parameter int debounce_scans_p = 4
) (
   input  logic       clk_i,
   input  logic       reset_i,
   input  logic [3:0] kpyd_row_i,
   output logic [3:0] kpyd_col_o,
   output logic       valid_o,
   input  logic       ready_i,
   output logic [3:0] key_code_o,
   output logic       key_down_o,
   output logic       held_valid_o,
   output logic [3:0] held_key_o,
   output logic       overrun_o
);

   localparam int cw_lp = $clog2(scan_cycles_p);
   localparam logic [cw_lp-1:0] last_lp = cw_lp'(scan_cycles_p - 1);
   localparam logic [3:0] dmax_lp = 4'(debounce_scans_p);

   typedef enum logic [1:0] {
      COL0,
      COL1,
      COL2,
      COL3
   } state_t;

   state_t           state_q, state_d;
   logic [cw_lp-1:0] cnt_q;
   logic [3:0]       row_s1_q, row_s2_q;
   logic [15:0]      snap_q, snap_d;
   logic             prev_v_q, stab_v_q;
   logic [3:0]       prev_k_q, stab_k_q, dcnt_q;
   logic             dwell_end, scan_done;
   logic             cand_v, same, differs, evt;
   logic [3:0]       cand_k, dcnt_d;
   logic [3:0]       col;

   always_comb begin
      state_d   = state_q;
      col       = 4'b1110;
      dwell_end = (cnt_q == last_lp);
      unique case (state_q)
         COL0: begin
            col = 4'b1110;
            if (dwell_end) state_d = COL1;
         end
         COL1: begin
            col = 4'b1101;
            if (dwell_end) state_d = COL2;
         end
         COL2: begin
            col = 4'b1011;
            if (dwell_end) state_d = COL3;
         end
         COL3: begin
            col = 4'b0111;
            if (dwell_end) state_d = COL0;
         end
      endcase
   end

   assign kpyd_col_o = col;
   assign scan_done  = dwell_end && (state_q == COL3);

   // Snapshot bit index is {row, col}, i.e. row*4 + col.
   always_comb begin
      snap_d = snap_q;
      if (dwell_end) begin
         for (int r = 0; r < 4; r++) begin
            snap_d[{2'(r), state_q}] = ~row_s2_q[r];
         end
      end
   end

   // Descending sweep leaves the lowest set index in cand_k.
   always_comb begin
      cand_v = |snap_d;
      cand_k = 4'd0;
      for (int i = 15; i >= 0; i--) begin
         if (snap_d[i]) cand_k = 4'(i);
      end
   end

   always_comb begin
      same    = (cand_v == prev_v_q) &&
                (!cand_v || cand_k == prev_k_q);
      differs = (cand_v != stab_v_q) ||
                (cand_v && cand_k != stab_k_q);
      if (!same)
         dcnt_d = 4'd1;
      else if (dcnt_q >= dmax_lp)
         dcnt_d = dmax_lp;
      else
         dcnt_d = dcnt_q + 4'd1;
      evt = scan_done && (dcnt_d == dmax_lp) && differs;
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q    <= COL0;
         cnt_q      <= '0;
         row_s1_q   <= 4'hF;
         row_s2_q   <= 4'hF;
         snap_q     <= '0;
         prev_v_q   <= 1'b0;
         prev_k_q   <= 4'd0;
         dcnt_q     <= 4'd0;
         stab_v_q   <= 1'b0;
         stab_k_q   <= 4'd0;
         valid_o    <= 1'b0;
         key_code_o <= 4'd0;
         key_down_o <= 1'b0;
         overrun_o  <= 1'b0;
      end else begin
         row_s1_q <= kpyd_row_i;
         row_s2_q <= row_s1_q;
         state_q  <= state_d;
         cnt_q    <= dwell_end ? '0 : cnt_q + 1'b1;
         snap_q   <= snap_d;
         if (scan_done) begin
            prev_v_q <= cand_v;
            prev_k_q <= cand_k;
            dcnt_q   <= dcnt_d;
         end
         if (evt) begin
            stab_v_q <= cand_v;
            if (cand_v) stab_k_q <= cand_k;
         end
         // A release reports the key that was held before it.
         if (evt && (!valid_o || ready_i)) begin
            valid_o    <= 1'b1;
            key_code_o <= cand_v ? cand_k : stab_k_q;
            key_down_o <= cand_v;
         end else if (evt) begin
            overrun_o <= 1'b1;
         end else if (valid_o && ready_i) begin
            valid_o <= 1'b0;
         end
      end
   end

   assign held_valid_o = stab_v_q;
   assign held_key_o   = stab_k_q;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Scenario bench for keypad_scan_ctrl: a keypad matrix model drives rows,
// and a per-scan reference of the debounce/event rules predicts outputs.
module tb_keypad_scan_ctrl;

   localparam int SC = 4;
   localparam int DB = 2;

   logic       clk_i = 1'b0;
   logic       reset_i = 1'b1;
   logic       ready_i = 1'b1;
   logic [3:0] kpyd_row_i;
   logic [3:0] kpyd_col_o;
   logic       valid_o;
   logic [3:0] key_code_o;
   logic       key_down_o;
   logic       held_valid_o;
   logic [3:0] held_key_o;
   logic       overrun_o;

   logic [15:0] keys = 16'h0;
   int checks = 0;
   int errors = 0;

   // Reference state, in key-code terms (-1 = no key).
   int m_prev, m_dcnt, m_stab, m_heldk, m_code;
   bit m_valid, m_down, m_ovr, m_mid;

   logic [3:0]  obs_col [1:16];
   logic [13:0] obs_st, exp_st;

   keypad_scan_ctrl #(
      .scan_cycles_p   (SC),
      .debounce_scans_p(DB)
   ) dut (
      .clk_i       (clk_i),
      .reset_i     (reset_i),
      .kpyd_row_i  (kpyd_row_i),
      .kpyd_col_o  (kpyd_col_o),
      .valid_o     (valid_o),
      .ready_i     (ready_i),
      .key_code_o  (key_code_o),
      .key_down_o  (key_down_o),
      .held_valid_o(held_valid_o),
      .held_key_o  (held_key_o),
      .overrun_o   (overrun_o)
   );

   always #5 clk_i = ~clk_i;

   always_comb begin
      kpyd_row_i = 4'hF;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (!kpyd_col_o[c] && keys[r*4+c])
               kpyd_row_i[r] = 1'b0;
   end

   function automatic int lowest(input logic [15:0] k);
      for (int i = 0; i < 16; i++)
         if (k[i]) return i;
      return -1;
   endfunction

   task automatic model_reset();
      m_prev = -1; m_dcnt = 0; m_stab = -1; m_heldk = 0;
      m_code = 0; m_valid = 0; m_down = 0; m_ovr = 0; m_mid = 0;
   endtask

   // One full scan with constant keys and ready.
   task automatic model_scan(input logic [15:0] k, input logic rdy);
      int cand;
      int code;
      cand = lowest(k);
      if (m_valid && rdy) m_valid = 0;
      m_mid = m_valid;
      if (cand == m_prev)
         m_dcnt = (m_dcnt + 1 > DB) ? DB : m_dcnt + 1;
      else
         m_dcnt = 1;
      m_prev = cand;
      if (m_dcnt == DB && cand != m_stab) begin
         code = (cand >= 0) ? cand : m_stab;
         m_stab = cand;
         if (cand >= 0) m_heldk = cand;
         if (!m_valid) begin
            m_valid = 1;
            m_code = code;
            m_down = (cand >= 0);
         end else begin
            m_ovr = 1;
         end
      end
      exp_st = {m_valid, 4'(m_code), m_down, m_stab >= 0,
                4'(m_heldk), m_ovr, m_mid, 1'b0};
   endtask

   task automatic do_scan(input logic [15:0] k, input logic rdy);
      bit chg, pv;
      logic [3:0] pc;
      logic pd, mid;
      keys = k;
      ready_i = rdy;
      model_scan(k, rdy);
      chg = 0; pv = 0; pc = 0; pd = 0; mid = 0;
      for (int i = 1; i <= 16; i++) begin
         @(posedge clk_i);
         #1;
         obs_col[i] = kpyd_col_o;
         if (i == 8) mid = valid_o;
         if (!rdy && pv && valid_o &&
             (key_code_o !== pc || key_down_o !== pd))
            chg = 1;
         pv = valid_o; pc = key_code_o; pd = key_down_o;
      end
      obs_st = {valid_o, key_code_o, key_down_o, held_valid_o,
                held_key_o, overrun_o, mid, chg};
   endtask

   task automatic test_reset();
      logic [3:0] ec;
      keys = 16'h0;
      ready_i = 1'b1;
      reset_i = 1'b1;
      model_reset();
      repeat (2) @(posedge clk_i);
      #1;
      if ({kpyd_col_o, valid_o, key_code_o, key_down_o, held_valid_o,
           held_key_o, overrun_o} !== {4'b1110, 1'b0, 4'd0, 1'b0, 1'b0,
           4'd0, 1'b0}) begin
         errors++;
         $display("FAIL reset_vals: got col=%b v=%b code=%0d dn=%b hv=%b hk=%0d ov=%b expected col=1110 and zeros",
                  kpyd_col_o, valid_o, key_code_o, key_down_o,
                  held_valid_o, held_key_o, overrun_o);
      end
      checks++;
      @(negedge clk_i);
      reset_i = 1'b0;
      for (int s = 0; s < 2; s++) begin
         do_scan(16'h0, 1'b1);
         for (int i = 1; i <= 16; i++) begin
            ec = ~(4'b0001 << ((i / 4) % 4));
            if (obs_col[i] !== ec) begin
               errors++;
               $display("FAIL col_seq s%0d i%0d: got %b expected %b",
                        s, i, obs_col[i], ec);
            end
            checks++;
         end
         if (obs_st !== exp_st) begin
            errors++;
            $display("FAIL idle s%0d: got %h expected %h",
                     s, obs_st, exp_st);
         end
         checks++;
      end
   endtask

   task automatic test_press();
      for (int s = 0; s < 3; s++) begin
         do_scan(16'h0040, 1'b1);
         if (obs_st !== exp_st) begin
            errors++;
            $display("FAIL press s%0d: got %h expected %h",
                     s, obs_st, exp_st);
         end
         checks++;
         if (s == 1 && {valid_o, key_code_o, key_down_o, held_valid_o,
                        held_key_o} !== {1'b1, 4'd6, 1'b1, 1'b1, 4'd6}) begin
            errors++;
            $display("FAIL press_6: got v=%b code=%0d dn=%b hv=%b hk=%0d expected 1/6/1/1/6",
                     valid_o, key_code_o, key_down_o, held_valid_o, held_key_o);
         end
         if (s == 1) checks++;
      end
   endtask

   task automatic test_release();
      for (int s = 0; s < 2; s++) begin
         do_scan(16'h0000, 1'b1);
         if (obs_st !== exp_st) begin
            errors++;
            $display("FAIL release s%0d: got %h expected %h",
                     s, obs_st, exp_st);
         end
         checks++;
      end
      if ({valid_o, key_code_o, key_down_o, held_valid_o} !==
          {1'b1, 4'd6, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL release_6: got v=%b code=%0d dn=%b hv=%b expected 1/6/0/0",
                  valid_o, key_code_o, key_down_o, held_valid_o);
      end
      checks++;
   endtask

   task automatic test_bounce();
      logic [15:0] seq [3] = '{16'h0001, 16'h0000, 16'h0000};
      for (int s = 0; s < 3; s++) begin
         do_scan(seq[s], 1'b1);
         if (obs_st !== exp_st) begin
            errors++;
            $display("FAIL bounce s%0d: got %h expected %h",
                     s, obs_st, exp_st);
         end
         checks++;
         if (s > 0 && (valid_o !== 1'b0 || held_valid_o !== 1'b0)) begin
            errors++;
            $display("FAIL bounce_quiet s%0d: got v=%b hv=%b expected 0/0",
                     s, valid_o, held_valid_o);
         end
         if (s > 0) checks++;
      end
   endtask

   task automatic test_multi();
      logic [15:0] seq [4] = '{16'h0208, 16'h0208, 16'h0200, 16'h0200};
      for (int s = 0; s < 4; s++) begin
         do_scan(seq[s], 1'b1);
         if (obs_st !== exp_st) begin
            errors++;
            $display("FAIL multi s%0d: got %h expected %h",
                     s, obs_st, exp_st);
         end
         checks++;
      end
      if ({key_code_o, key_down_o, held_key_o} !== {4'd9, 1'b1, 4'd9}) begin
         errors++;
         $display("FAIL multi_9: got code=%0d dn=%b hk=%0d expected 9/1/9",
                  key_code_o, key_down_o, held_key_o);
      end
      checks++;
   endtask

   task automatic test_backpressure();
      logic [15:0] ks [8] = '{16'h0, 16'h0, 16'h0, 16'h8000, 16'h8000,
                              16'h0, 16'h0, 16'h0};
      bit          rs [8] = '{1, 1, 1, 0, 0, 0, 0, 1};
      for (int s = 0; s < 8; s++) begin
         do_scan(ks[s], rs[s]);
         if (obs_st !== exp_st) begin
            errors++;
            $display("FAIL backpr s%0d: got %h expected %h",
                     s, obs_st, exp_st);
         end
         checks++;
         if (s == 6 && {valid_o, key_code_o, key_down_o, overrun_o,
                        held_valid_o} !== {1'b1, 4'd15, 1'b1, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL overrun_15: got v=%b code=%0d dn=%b ov=%b hv=%b expected 1/15/1/1/0",
                     valid_o, key_code_o, key_down_o, overrun_o, held_valid_o);
         end
         if (s == 6) checks++;
      end
      repeat (5) @(posedge clk_i);
      #2;
      reset_i = 1'b1;
      #1;
      if ({kpyd_col_o, valid_o, key_code_o, key_down_o, held_valid_o,
           held_key_o, overrun_o} !== {4'b1110, 1'b0, 4'd0, 1'b0, 1'b0,
           4'd0, 1'b0}) begin
         errors++;
         $display("FAIL mid_reset: got col=%b v=%b code=%0d dn=%b hv=%b hk=%0d ov=%b expected col=1110 and zeros",
                  kpyd_col_o, valid_o, key_code_o, key_down_o,
                  held_valid_o, held_key_o, overrun_o);
      end
      checks++;
      model_reset();
      keys = 16'h0;
      @(negedge clk_i);
      reset_i = 1'b0;
   endtask

   task automatic test_random();
      logic [15:0] k;
      logic [15:0] prev;
      bit rdy;
      prev = 16'h0;
      for (int s = 0; s < 60; s++) begin
         if ($urandom_range(0, 2) != 0) begin
            k = prev;
         end else begin
            case ($urandom_range(0, 3))
               0: k = 16'h0;
               1: k = 16'(1) << $urandom_range(0, 15);
               default: k = (16'(1) << $urandom_range(0, 15)) |
                            (16'(1) << $urandom_range(0, 15));
            endcase
         end
         rdy = ($urandom_range(0, 3) != 0);
         do_scan(k, rdy);
         if (obs_st !== exp_st) begin
            errors++;
            $display("FAIL random s%0d keys=%h rdy=%b: got %h expected %h",
                     s, k, rdy, obs_st, exp_st);
         end
         checks++;
         prev = k;
      end
   endtask

   initial begin
      test_reset();
      test_press();
      test_release();
      test_bounce();
      test_multi();
      test_backpressure();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/keypad_scan_ctrl.md
# keypad_scan_ctrl

Scans the 4x4 keypad matrix, debounces the result and turns it into press/release events. Events leave through a one-entry ready/valid output, and a level `held` output tracks the debounced key. It sits between the board keypad pins (`kpyd_row_i`/`kpyd_col_o` on `top`) and the note-selection logic that configures and gates the sine/square/triangle/sawtooth generators. The last pressed key selects the note and enables the voice; release mutes it.

## Interface
Parameters:
- `scan_cycles_p`, default 50000: clock cycles each column is driven (dwell). Legal range ≥ 4.
- `debounce_scans_p`, default 4: consecutive identical full scans required to accept a change. Legal range 1..15.

Ports:
- `clk_i` input, 1: system clock.
- `reset_i` input, 1: asynchronous, active-high reset.
- `kpyd_row_i` input, 4: keypad rows, active-low (pulled up), asynchronous to `clk_i`.
- `kpyd_col_o` output, 4: column drive, active-low one-hot.
- `valid_o` output, 1: event available.
- `ready_i` input, 1: consumer accepts the event.
- `key_code_o` output, 4: event key code, equal to `row*4 + col`.
- `key_down_o` output, 1: event type. 1 = press, 0 = release.
- `held_valid_o` output, 1: a debounced key is currently held.
- `held_key_o` output, 4: the debounced held key code.
- `overrun_o` output, 1: sticky flag, set when an event is dropped.

## Operation
Row synchronization:
- `kpyd_row_i` passes through a 2-flop synchronizer before any use.

Scan FSM: states `COL0`..`COL3`, with a dwell counter `cnt` running 0..`scan_cycles_p`-1.
- In state `COLc`, `kpyd_col_o` = ~(1<<c).
- When `cnt` reaches `scan_cycles_p`-1:
  - sample the synchronized rows into snapshot bits [r*4+c] (pressed = row bit low),
  - advance to the next column. `COL3` wraps to `COL0`.
- The `COL3` sample completes a scan of 4*`scan_cycles_p` cycles.

Candidate encoding:
- At scan completion the candidate is the lowest-index set bit of the 16-bit snapshot, or NONE if the snapshot is zero.
- Multiple simultaneous keys therefore resolve to the lowest code.

Debounce:
- If the candidate equals the previous candidate, `dcnt` = min(`dcnt`+1, `debounce_scans_p`). Otherwise `dcnt` = 1.
- The previous candidate is then updated to the current candidate.
- If the new `dcnt` equals `debounce_scans_p` and the candidate differs from the stable value:
  - the stable value is updated to the candidate,
  - one event is generated.

Event content:
- Stable changes to key K (from NONE or from another key): code = K, down = 1. No separate release is generated for the old key.
- Stable changes to NONE from K: code = K, down = 0.

Held outputs:
- `held_valid_o`/`held_key_o` mirror the stable value at all times.
- `held_key_o` keeps its last value while `held_valid_o` = 0.

Output buffer (one entry):
- An event loads `key_code_o`/`key_down_o` and sets `valid_o` when either:
  - `valid_o` = 0, or
  - `valid_o` && `ready_i` in the same cycle. In this case `valid_o` stays 1 and the new data replaces the old.
- `valid_o` && `ready_i` with no new event clears `valid_o`.
- `valid_o` && !`ready_i` with a new event:
  - the new event is dropped,
  - `overrun_o` is set,
  - the buffered event is unchanged,
  - held outputs still update.
- While `valid_o` = 1 and `ready_i` = 0, the output data must not change.

## Timing
Reset values (asynchronous assertion):
- FSM state = `COL0`, so `kpyd_col_o` = 4'b1110. `cnt` = 0.
- Snapshot = 0, previous candidate = NONE, `dcnt` = 0, stable = NONE.
- `valid_o` = 0, `key_code_o` = 0, `key_down_o` = 0.
- `held_valid_o` = 0, `held_key_o` = 0, `overrun_o` = 0.
- Reset mid-scan or mid-handshake discards all state. The first post-reset scan starts at `COL0` with `cnt` = 0.

Scan timing:
- Each column is driven for exactly `scan_cycles_p` cycles.
- The row sample is taken on the last dwell cycle, which gives ≥ `scan_cycles_p`-3 cycles of settle after the synchronizer.

Event latency:
- `valid_o` and the held outputs update on the cycle after the clock edge that samples `COL3` of the accepting scan.
- With a press stable from reset, the first event appears `debounce_scans_p` scans after reset, plus 1 cycle.

Other timing rules:
- Dwell counter and column wrap are free-running. They are never stalled by `ready_i`.
- `overrun_o` clears only on reset.

## Test plan
Common setup for all scenarios: `scan_cycles_p`=4, `debounce_scans_p`=2 (scan = 16 cycles). The bench contains a keypad model that pulls row r low while col c is low and key (r,c) is pressed.

- Reset only, no keys:
  - `kpyd_col_o` cycles 1110→1101→1011→0111 every 4 cycles.
  - `valid_o`, `held_valid_o` and `overrun_o` stay 0.
- Hold key (1,2) from reset, `ready_i`=1:
  - after scan 2 completes: one-cycle `valid_o` with `key_code_o`=6, `key_down_o`=1,
  - `held_valid_o`=1, `held_key_o`=6.
- Release key (1,2) after it is accepted:
  - after 2 clean scans: event `key_code_o`=6, `key_down_o`=0,
  - `held_valid_o`=0.
- Bounce: press (0,0) for one scan only, then clear:
  - no event,
  - held outputs unchanged.
- Hold keys (2,1) and (0,3) together:
  - event code 3, down=1.
  - Then release (0,3): event code 9, down=1, with no release event for 3.
- Backpressure:
  - With `ready_i`=0, press (3,3): `valid_o`=1, code 15.
  - Then release it while still not ready: `overrun_o`=1, output stays code 15/down=1, `held_valid_o`=0.
  - Assert `ready_i`: `valid_o` clears.
  - Assert `reset_i` mid-dwell: all outputs return to their reset values immediately.
